// File: rtl/pc_reg_pkg.sv
// Shared fetch-path definitions: address width, reset/zero address, enable levels and
// the per-instruction pc step.
package pc_reg_pkg;

    localparam int unsigned AddrBus = 32;

    localparam logic [AddrBus-1:0] ZeroPc   = '0;
    localparam logic [AddrBus-1:0] InstStep = AddrBus'(4);

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

endpackage

// File: rtl/pc_reg.sv
// Program counter for the fetch stage: sequences the fetch address and tracks a redirect
// that arrives while a fetch is still outstanding. Also counts completed fetches.
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter logic [AddrBus-1:0] RESET_PC = ZeroPc
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_IF_wait,
    input  logic               i_ID_stall,
    input  logic               i_EX_branch_en,
    input  logic [AddrBus-1:0] i_EX_branch_addr,
    output logic [AddrBus-1:0] o_IF_pc,
    output logic               o_IF_valid,
    output logic               o_redir_pending,
    output logic [31:0]        o_fetch_cnt
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StWait,
        StPend
    } state_e;

    state_e             state_q, state_d;
    logic [AddrBus-1:0] pc_q, pc_d;
    logic [AddrBus-1:0] pend_q, pend_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               redir_q, redir_d;
    logic [AddrBus-1:0] br_tgt;

    assign br_tgt = {i_EX_branch_addr[AddrBus-1:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        redir_d = redir_q;

        case (state_q)
            StBoot: begin
                state_d = StRun;
                pc_d    = RESET_PC;
                valid_d = Enable;
            end
            StRun, StWait: begin
                if (i_IF_wait) begin
                    // The outstanding fetch must return before the redirect can be issued.
                    if (i_EX_branch_en) begin
                        pend_d  = br_tgt;
                        redir_d = Enable;
                        state_d = StPend;
                    end else begin
                        state_d = StWait;
                    end
                end else begin
                    state_d = StRun;
                    if (i_EX_branch_en) begin
                        pc_d = br_tgt;
                    end else if (!i_ID_stall) begin
                        pc_d = pc_q + InstStep;
                    end
                end
            end
            StPend: begin
                // First deferred target wins; later branches and stalls cannot displace it.
                if (!i_IF_wait) begin
                    pc_d    = pend_q;
                    pend_d  = ZeroPc;
                    redir_d = Disable;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        if (state_q != StBoot && valid_q && !i_IF_wait) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            pend_q  <= ZeroPc;
            cnt_q   <= '0;
            valid_q <= Disable;
            redir_q <= Disable;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            redir_q <= redir_d;
        end
    end

    assign o_IF_pc         = pc_q;
    assign o_IF_valid      = valid_q;
    assign o_redir_pending = redir_q;
    assign o_fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed scenarios plus randomized traffic compared
// against a behavioural model of the fetch sequencing rules.
module tb_pc_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_wait = 1'b0;
    logic        id_stall = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_addr = '0;
    logic [31:0] pc;
    logic        valid;
    logic        redir;
    logic [31:0] fcnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_boot = 1'b1;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_addr = '0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_cnt = '0;

    pc_reg #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_IF_wait       (if_wait),
        .i_ID_stall      (id_stall),
        .i_EX_branch_en  (br_en),
        .i_EX_branch_addr(br_addr),
        .o_IF_pc         (pc),
        .o_IF_valid      (valid),
        .o_redir_pending (redir),
        .o_fetch_cnt     (fcnt)
    );

    always #5 clk = ~clk;

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic tick();
        logic [31:0] tgt;
        tgt = br_addr & 32'hFFFF_FFFC;
        if (rst) begin
            m_boot = 1'b1;
            m_pend = 1'b0;
            m_pend_addr = '0;
            m_pc = 32'h0;
            m_cnt = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_pc = 32'h0;
        end else begin
            if (!if_wait) m_cnt = m_cnt + 1;
            if (m_pend) begin
                if (!if_wait) begin
                    m_pc = m_pend_addr;
                    m_pend = 1'b0;
                end
            end else if (br_en) begin
                if (if_wait) begin
                    m_pend = 1'b1;
                    m_pend_addr = tgt;
                end else begin
                    m_pc = tgt;
                end
            end else if (!if_wait && !id_stall) begin
                m_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic w, input logic s, input logic b, input logic [31:0] a);
        if_wait = w;
        id_stall = s;
        br_en = b;
        br_addr = a;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go(0, 0, 1, 32'h1234);
        go(1, 1, 1, 32'h5678);
        checks++;
        if ({pc, valid, redir, fcnt} !== {32'h0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_state: got pc=%h valid=%b redir=%b cnt=%0d, need 0/0/0/0",
                     pc, valid, redir, fcnt);
        end
        rst = 1'b0;
        go(0, 0, 1, 32'h800);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h0 || fcnt !== 32'd0) begin
            failures++;
            $display("FAIL boot_to_run: got pc=%h valid=%b cnt=%0d, need 0/1/0", pc, valid, fcnt);
        end
        for (int i = 1; i <= 3; i++) begin
            go(0, 0, 0, 32'h0);
            checks++;
            if (pc !== 32'(4 * i) || fcnt !== 32'(i)) begin
                failures++;
                $display("FAIL free_run[%0d]: got pc=%h cnt=%0d, need pc=%h cnt=%0d",
                         i, pc, fcnt, 4 * i, i);
            end
        end
    endtask

    task automatic test_wait_hold();
        logic [31:0] c0;
        go(0, 0, 1, 32'h10);
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            go(1, 0, 0, 32'h0);
            checks++;
            if (pc !== 32'h10 || fcnt !== c0 || redir !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold[%0d]: got pc=%h cnt=%0d redir=%b, need pc=10 cnt=%0d redir=0",
                         i, pc, fcnt, redir, c0);
            end
        end
        go(0, 0, 0, 32'h0);
        checks++;
        if (pc !== 32'h14 || fcnt !== c0 + 1) begin
            failures++;
            $display("FAIL wait_release: got pc=%h cnt=%0d, need pc=14 cnt=%0d", pc, fcnt, c0 + 1);
        end
    endtask

    task automatic test_pending_redirect();
        go(0, 0, 1, 32'h20);
        go(1, 0, 1, 32'h103);
        checks++;
        if (pc !== 32'h20 || redir !== 1'b1) begin
            failures++;
            $display("FAIL pend_enter: got pc=%h redir=%b, need pc=20 redir=1", pc, redir);
        end
        go(1, 0, 1, 32'h200);
        checks++;
        if (pc !== 32'h20 || redir !== 1'b1) begin
            failures++;
            $display("FAIL pend_hold: got pc=%h redir=%b, need pc=20 redir=1", pc, redir);
        end
        go(0, 1, 1, 32'h400);
        checks++;
        if (pc !== 32'h100 || redir !== 1'b0) begin
            failures++;
            $display("FAIL pend_issue: got pc=%h redir=%b, need pc=100 redir=0", pc, redir);
        end
    endtask

    task automatic test_stall_branch();
        go(0, 0, 1, 32'h40);
        go(0, 1, 1, 32'h80);
        checks++;
        if (pc !== 32'h80) begin
            failures++;
            $display("FAIL stall_branch: got pc=%h, need pc=80", pc);
        end
        go(0, 1, 0, 32'h0);
        checks++;
        if (pc !== 32'h80) begin
            failures++;
            $display("FAIL stall_hold: got pc=%h, need pc=80", pc);
        end
    endtask

    task automatic test_wrap();
        go(0, 0, 1, 32'hFFFF_FFFF);
        go(0, 0, 0, 32'h0);
        checks++;
        if (pc !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap: got pc=%h, need pc=00000000", pc);
        end
    endtask

    task automatic test_reset_in_pend();
        go(0, 0, 1, 32'h50);
        go(1, 0, 1, 32'h300);
        rst = 1'b1;
        go(1, 0, 0, 32'h0);
        checks++;
        if ({pc, valid, redir, fcnt} !== {32'h0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_pend: got pc=%h valid=%b redir=%b cnt=%0d, need 0/0/0/0",
                     pc, valid, redir, fcnt);
        end
        rst = 1'b0;
        go(0, 0, 0, 32'h0);
        go(0, 0, 0, 32'h0);
        checks++;
        if (pc !== 32'h4 || fcnt !== 32'd1 || redir !== 1'b0) begin
            failures++;
            $display("FAIL reset_pend_discard: got pc=%h cnt=%0d redir=%b, need pc=4 cnt=1 redir=0",
                     pc, fcnt, redir);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            go(logic'($urandom_range(0, 99) < 40), logic'($urandom_range(0, 99) < 30),
               logic'($urandom_range(0, 99) < 20), $urandom);
            checks++;
            if ({pc, valid, redir, fcnt} !== {m_pc, !m_boot, m_pend, m_cnt}) begin
                failures++;
                $display("FAIL random[%0d]: got pc=%h valid=%b redir=%b cnt=%0d, need pc=%h valid=%b redir=%b cnt=%0d",
                         i, pc, valid, redir, fcnt, m_pc, !m_boot, m_pend, m_cnt);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wait_hold();
        test_pending_redirect();
        test_stall_branch();
        test_wrap();
        test_reset_in_pend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
PC_REG -- requirements
Module: pc_reg

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address issued after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_IF_wait  input  1  IF fetch outstanding (MMU not yet returned current pc); hold pc.
REQ-005 i_ID_stall  input  1  decode cannot accept; hold pc.
REQ-006 i_EX_branch_en  input  1  taken branch/jump resolved this cycle.
REQ-007 i_EX_branch_addr  input  32  branch target.
REQ-008 o_IF_pc  output  32  current fetch address to IF.
REQ-009 o_IF_valid  output  1  o_IF_pc is a real fetch request.
REQ-010 o_redir_pending  output  1  a deferred redirect is held.
REQ-011 o_fetch_cnt  output  32  count of completed fetches (perf counter).

Function
REQ-012 FSM states SHALL be BOOT, RUN, WAIT, PEND.
REQ-013 BOOT: o_IF_valid=0, o_IF_pc=RESET_PC; next cycle unconditionally RUN with o_IF_valid=1, o_IF_pc=RESET_PC.
REQ-014 A fetch "completes" in a cycle where state is RUN/WAIT/PEND, o_IF_valid=1 and i_IF_wait=0; o_fetch_cnt SHALL then increment by 1, wrapping at 2^32.
REQ-015 RUN, i_IF_wait=0, i_ID_stall=0, no branch: o_IF_pc <= o_IF_pc+4 next cycle (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-016 RUN, i_IF_wait=1, no branch: pc held, go WAIT.
REQ-017 RUN or WAIT, i_ID_stall=1, i_IF_wait=0, no branch: pc held, state RUN.
REQ-018 Branch with i_IF_wait=0 in RUN/WAIT: o_IF_pc <= {i_EX_branch_addr[31:2],2'b00} next cycle, regardless of i_ID_stall; state RUN.
REQ-019 Branch with i_IF_wait=1 in RUN/WAIT: target (low 2 bits cleared) latched into pending register, pc held, go PEND, o_redir_pending=1 next cycle.
REQ-020 PEND, i_IF_wait=1: pc held; further i_EX_branch_en ignored (first target wins).
REQ-021 PEND, i_IF_wait=0: o_IF_pc <= pending target next cycle, pending cleared, state RUN, o_redir_pending=0; i_ID_stall and a same-cycle new branch do not override the pending target.
REQ-022 WAIT, i_IF_wait=0, no branch, i_ID_stall=0: pc+4, state RUN.
REQ-023 o_IF_valid SHALL be 1 in RUN/WAIT/PEND and 0 only in BOOT.
REQ-024 Branch during BOOT SHALL be ignored.

Reset
REQ-025 rst=1 at a clock edge SHALL, in any state and overriding all inputs: state BOOT, o_IF_pc=RESET_PC, o_IF_valid=0, pending cleared, o_redir_pending=0, o_fetch_cnt=0.
REQ-026 Reset mid-WAIT/PEND SHALL discard the pending target; no fetch counted on the reset edge.

Structure
REQ-027 AddrBus width, ZeroPc, Enable/Disable, and instruction-step constant 4 SHALL come from the shared defines file; FSM encoding SHALL be local to pc_reg.
REQ-028 No sub-module: single flat module, one sequential process plus next-state logic.

Verification
REQ-029 Reset release, wait=0, stall=0: cycle0 valid=0 pc=0; then pc 0,4,8,12; fetch_cnt 0,1,2,3.
REQ-030 pc=0x10, wait=1 for 3 cycles, then 0: pc stays 0x10 throughout, state WAIT, fetch_cnt +1 only on release, then pc=0x14.
REQ-031 pc=0x20, wait=1, branch_en pulse target 0x103: pending=1, pc stays 0x20; second branch 0x200 ignored; wait drops -> pc=0x100, pending=0.
REQ-032 pc=0x40, stall=1, wait=0, branch target 0x80 -> pc=0x80 next cycle despite stall.
REQ-033 pc=0xFFFF_FFFC, run free -> next pc=0x0000_0000.
REQ-034 In PEND with target 0x300, assert rst -> pc=RESET_PC, valid=0, pending=0, fetch_cnt=0; target never issued.
